// File: rtl/prim_fifo_async_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prim_fifo_async_pkg
//  Purpose  : Shared pointer-width derivations and Gray code helpers used by
//             both the read-side and write-side async FIFO controllers.
//  Revision : 1.0 - initial release
// ============================================================================
package prim_fifo_async_pkg;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int depth_w(input int depth);
      return $clog2(depth + 2);
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Callers zero-extend narrower pointers, so the unused upper bits decode to 0.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prim_fifo_async_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : prim_fifo_async_rd_ctrl_if
//  Purpose  : Pointer, storage and output-handshake bundle of the async FIFO
//             read controller; slave is the controller, master its environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface prim_fifo_async_rd_ctrl_if
   import prim_fifo_async_pkg::*;
#(
   parameter int Width = 16,
   parameter int Depth = 4
);
   localparam int PtrW   = ptr_w(Depth);
   localparam int DepthW = depth_w(Depth);

   logic [PtrW-1:0]   wptr_gray_i;
   logic [PtrW-1:0]   rptr_gray_o;
   logic [PtrW-2:0]   raddr_o;
   logic [Width-1:0]  mem_rdata_i;
   logic              rvalid_o;
   logic              rready_i;
   logic [Width-1:0]  rdata_o;
   logic [DepthW-1:0] rdepth_o;
   logic              err_o;

   modport master (
      output wptr_gray_i, mem_rdata_i, rready_i,
      input  rptr_gray_o, raddr_o, rvalid_o, rdata_o, rdepth_o, err_o
   );

   modport slave (
      input  wptr_gray_i, mem_rdata_i, rready_i,
      output rptr_gray_o, raddr_o, rvalid_o, rdata_o, rdepth_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/prim_gray_ptr_sync.sv
`default_nettype none
// ============================================================================
//  Module   : prim_gray_ptr_sync
//  Purpose  : Two-flop synchronizer for a Gray-coded pointer from a foreign
//             clock domain; async active-high reset to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module prim_gray_ptr_sync #(
   parameter int Width = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);
   logic [Width-1:0] r_meta;
   logic [Width-1:0] r_sync;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;
endmodule
`default_nettype wire

// File: rtl/prim_fifo_async_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prim_fifo_async_rd_ctrl
//  Purpose  : Read-side controller of an async FIFO: syncs the write pointer,
//             drives the storage address and a registered valid/ready output.
//  Revision : 1.0 - initial release
// ============================================================================
module prim_fifo_async_rd_ctrl
   import prim_fifo_async_pkg::*;
#(
   parameter int Width = 16,
   parameter int Depth = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   prim_fifo_async_rd_ctrl_if.slave    bus
);
   localparam int PtrW   = ptr_w(Depth);
   localparam int DepthW = depth_w(Depth);
   localparam logic [PtrW-1:0] c_DEPTH = PtrW'(Depth);

   logic [PtrW-1:0]  w_wptr_gray_sync;
   logic [PtrW-1:0]  w_wptr_bin;
   logic [PtrW-1:0]  w_occ;
   logic             w_empty;
   logic             w_illegal;
   logic             w_load;
   logic [PtrW-1:0]  w_rptr_nxt;

   logic [PtrW-1:0]  r_rptr;
   logic [PtrW-1:0]  r_rptr_gray;
   logic             r_rvalid;
   logic [Width-1:0] r_rdata;
   logic             r_err;

   prim_gray_ptr_sync #(
      .Width (PtrW)
   ) u_wptr_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (bus.wptr_gray_i),
      .q_o   (w_wptr_gray_sync)
   );

   assign w_wptr_bin = PtrW'(gray2bin(32'(w_wptr_gray_sync)));
   assign w_occ      = w_wptr_bin - r_rptr;
   assign w_empty    = (w_occ == '0);
   assign w_illegal  = (w_occ > c_DEPTH);
   assign w_load     = !w_empty && !w_illegal && (!r_rvalid || bus.rready_i);
   assign w_rptr_nxt = w_load ? r_rptr + 1'b1 : r_rptr;

   // Gray pointer is registered from the next binary value so it tracks rptr
   // exactly and moves by a single bit per increment.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rptr      <= '0;
         r_rptr_gray <= '0;
         r_rvalid    <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_rptr      <= w_rptr_nxt;
         r_rptr_gray <= PtrW'(bin2gray(32'(w_rptr_nxt)));
         if (w_illegal) begin
            r_err <= 1'b1;
         end
         if (w_load) begin
            r_rdata  <= bus.mem_rdata_i;
            r_rvalid <= 1'b1;
         end else if (r_rvalid && bus.rready_i) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign bus.rptr_gray_o = r_rptr_gray;
   assign bus.raddr_o     = r_rptr[PtrW-2:0];
   assign bus.rvalid_o    = r_rvalid;
   assign bus.rdata_o     = r_rdata;
   assign bus.rdepth_o    = DepthW'(w_occ) + DepthW'(r_rvalid);
   assign bus.err_o       = r_err;
endmodule
`default_nettype wire
